// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM-to-AXI-Stream burst reader.
package ram_stream_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Word written back after each read when clear-after-read is built in.
   localparam int CLEAR_VALUE_DEFAULT = 0;

endpackage

// File: rtl/ram_stream_reader_skid.sv
// Two-entry output FIFO: entry 0 is always the head presented to the stream,
// so the head only moves on a pop (or when filling an empty FIFO).
module stream_skid_fifo #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);

   logic [W-1:0] e0_q, e0_d;
   logic [W-1:0] e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         pop_ok;
   logic         push_ok;

   // next-state for the two entries and the occupancy
   always_comb begin
      e0_d    = e0_q;
      e1_d    = e1_q;
      cnt_d   = cnt_q;
      pop_ok  = pop && (cnt_q != 2'd0);
      push_ok = push && ((cnt_q != 2'd2) || pop_ok);
      case ({push_ok, pop_ok})
         2'b10: begin
            if (cnt_q == 2'd0) e0_d = push_data;
            else               e1_d = push_data;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               e0_d = push_data;
            end else begin
               e0_d = e1_q;
               e1_d = push_data;
            end
         end
         default: ;
      endcase
   end

   // entry and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = e0_q;
   assign count     = cnt_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a burst of RAM words out on an AXI-Stream master.
// Optional build macro RAM_STREAM_READER_CLEAR_EN adds a write port that
// clears each word one cycle after it is read.
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int MEM_SIZE    = 14,
   parameter int MEM_WIDTH   = 16,
   parameter int CLEAR_VALUE = CLEAR_VALUE_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [MEM_SIZE-1:0]    startAddr,
   input  logic [MEM_SIZE:0]      length,
   output logic                   busy,
   output logic                   done,
   output logic                   readCs,
   output logic [MEM_SIZE-1:0]    readAddr,
   input  logic [MEM_WIDTH-1:0]   readData,
`ifdef RAM_STREAM_READER_CLEAR_EN
   output logic                   writeCs,
   output logic                   write,
   output logic [MEM_SIZE-1:0]    writeAddr,
   output logic [MEM_WIDTH-1:0]   writeData,
   output logic [MEM_WIDTH/4-1:0] writeMask,
`endif
   output logic                   m_axis_tvalid,
   output logic [MEM_WIDTH-1:0]   m_axis_tdata,
   output logic                   m_axis_tlast,
   input  logic                   m_axis_tready
);

   state_t              state_q, state_d;
   logic [MEM_SIZE-1:0] addr_q, addr_d;
   logic [MEM_SIZE:0]   rem_q, rem_d;
   logic                done_q, done_d;
   logic                infl_q, infl_d;
   logic                infl_last_q, infl_last_d;

   logic                fifo_valid;
   logic [MEM_WIDTH:0]  fifo_out;
   logic [1:0]          fifo_cnt;
   logic                pop;
   logic [2:0]          used;
   logic                rd_en;

   // Credit check counts the beat leaving this cycle as already gone, which
   // is what lets a full-rate stream sustain one read per cycle.
   always_comb begin
      pop   = fifo_valid && m_axis_tready;
      used  = {1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, infl_q};
      rd_en = (state_q == ST_READ) && (used < 3'd2);
   end

   // burst FSM: next state, address/count bookkeeping, done pulse
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      done_d      = 1'b0;
      infl_d      = rd_en;
      infl_last_d = rd_en && (rem_q == (MEM_SIZE+1)'(1));
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  addr_d  = startAddr;
                  rem_d   = length;
                  state_d = ST_READ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (rd_en) begin
               addr_d = addr_q + MEM_SIZE'(1);
               rem_d  = rem_q - (MEM_SIZE+1)'(1);
               if (rem_q == (MEM_SIZE+1)'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && fifo_out[MEM_WIDTH]) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and read-pipeline registers; reset drops any in-flight read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         done_q      <= 1'b0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         done_q      <= done_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
      end
   end

   stream_skid_fifo #(.W(MEM_WIDTH+1)) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (infl_q),
      .push_data ({infl_last_q, readData}),
      .pop       (pop),
      .out_valid (fifo_valid),
      .out_data  (fifo_out),
      .count     (fifo_cnt)
   );

   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign readCs        = rd_en;
   assign readAddr      = addr_q;
   assign m_axis_tvalid = fifo_valid;
   assign m_axis_tdata  = fifo_out[MEM_WIDTH-1:0];
   assign m_axis_tlast  = fifo_valid && fifo_out[MEM_WIDTH];

`ifdef RAM_STREAM_READER_CLEAR_EN
   logic [MEM_SIZE-1:0] wr_addr_q, wr_addr_d;

   // remember the address being read so it can be cleared next cycle
   always_comb begin
      wr_addr_d = rd_en ? addr_q : wr_addr_q;
   end

   // clear-address register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wr_addr_q <= '0;
      else        wr_addr_q <= wr_addr_d;
   end

   assign writeCs   = infl_q;
   assign write     = infl_q;
   assign writeAddr = wr_addr_q;
   assign writeData = MEM_WIDTH'(CLEAR_VALUE);
   assign writeMask = '1;
`endif

endmodule
